// File: rtl/reg_file_hilo_cp0_if.sv
// Writeback/decode-facing bus of the architectural register store:
// unified register write, HI/LO write, two read ports, HI/LO and timer outputs.
interface reg_file_hilo_cp0_if #(
    parameter int WIDTH = 32
);
    logic               RegWriteW;
    logic [6:0]         WritetoRFaddr;
    logic [WIDTH-1:0]   WritetoRFdata;
    logic               HI_LO_writeenable;
    logic [2*WIDTH-1:0] WriteinRF_HI_LO_data;
    logic [6:0]         ReadAddr1;
    logic [6:0]         ReadAddr2;
    logic [WIDTH-1:0]   ReadData1;
    logic [WIDTH-1:0]   ReadData2;
    logic [WIDTH-1:0]   HI_out;
    logic [WIDTH-1:0]   LO_out;
    logic               timer_int;

    modport master (
        output RegWriteW, WritetoRFaddr, WritetoRFdata,
        output HI_LO_writeenable, WriteinRF_HI_LO_data,
        output ReadAddr1, ReadAddr2,
        input  ReadData1, ReadData2, HI_out, LO_out, timer_int
    );

    modport slave (
        input  RegWriteW, WritetoRFaddr, WritetoRFdata,
        input  HI_LO_writeenable, WriteinRF_HI_LO_data,
        input  ReadAddr1, ReadAddr2,
        output ReadData1, ReadData2, HI_out, LO_out, timer_int
    );
endinterface

// File: rtl/reg_file_hilo_cp0.sv
// Architectural state store: 32 GPRs, HI/LO, 32-entry CP0 bank with the
// Count/Compare timer, and write-through combinational read ports.
module reg_file_hilo_cp0 #(
    parameter int WIDTH = 32
) (
    input logic               clk,
    input logic               rst,
    reg_file_hilo_cp0_if.slave bus
);

    localparam logic [4:0] COUNT_IDX   = 5'd9;
    localparam logic [4:0] COMPARE_IDX = 5'd11;

    logic [WIDTH-1:0] gpr [32];
    logic [WIDTH-1:0] cp0 [32];
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             phase;
    logic             timer_int;

    logic wr_gpr;
    logic wr_cp0;
    logic wr_compare;

    // Address regions: 7'h00-1F GPR, 7'h40-5F CP0, everything else unmapped.
    function automatic logic is_gpr(input logic [6:0] addr);
        return addr[6:5] == 2'b00;
    endfunction

    function automatic logic is_cp0(input logic [6:0] addr);
        return addr[6:5] == 2'b10;
    endfunction

    function automatic logic is_writable(input logic [6:0] addr);
        return (is_gpr(addr) && addr[4:0] != 5'd0) || is_cp0(addr);
    endfunction

    assign wr_gpr     = bus.RegWriteW && is_gpr(bus.WritetoRFaddr) && bus.WritetoRFaddr[4:0] != 5'd0;
    assign wr_cp0     = bus.RegWriteW && is_cp0(bus.WritetoRFaddr);
    assign wr_compare = wr_cp0 && bus.WritetoRFaddr[4:0] == COMPARE_IDX;

    // A software write to Count is issued after the increment so it wins that edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                gpr[i] <= '0;
                cp0[i] <= '0;
            end
            hi        <= '0;
            lo        <= '0;
            phase     <= 1'b0;
            timer_int <= 1'b0;
        end else begin
            phase <= ~phase;
            if (phase)
                cp0[COUNT_IDX] <= cp0[COUNT_IDX] + 1'b1;
            if (wr_gpr)
                gpr[bus.WritetoRFaddr[4:0]] <= bus.WritetoRFdata;
            if (wr_cp0)
                cp0[bus.WritetoRFaddr[4:0]] <= bus.WritetoRFdata;
            if (wr_compare)
                timer_int <= 1'b0;
            else if (cp0[COUNT_IDX] == cp0[COMPARE_IDX])
                timer_int <= 1'b1;
            if (bus.HI_LO_writeenable) begin
                hi <= bus.WriteinRF_HI_LO_data[2*WIDTH-1:WIDTH];
                lo <= bus.WriteinRF_HI_LO_data[WIDTH-1:0];
            end
        end
    end

    function automatic logic [WIDTH-1:0] read_port(input logic [6:0] addr);
        logic [WIDTH-1:0] value;
        value = '0;
        if (!rst) begin
            if (bus.RegWriteW && addr == bus.WritetoRFaddr && is_writable(addr))
                value = bus.WritetoRFdata;
            else if (is_gpr(addr))
                value = gpr[addr[4:0]];
            else if (is_cp0(addr))
                value = cp0[addr[4:0]];
        end
        return value;
    endfunction

    // Write-through is suppressed while reset is held so everything reads zero.
    always_comb begin
        bus.ReadData1 = read_port(bus.ReadAddr1);
        bus.ReadData2 = read_port(bus.ReadAddr2);
        bus.HI_out    = hi;
        bus.LO_out    = lo;
        if (rst) begin
            bus.HI_out = '0;
            bus.LO_out = '0;
        end else if (bus.HI_LO_writeenable) begin
            bus.HI_out = bus.WriteinRF_HI_LO_data[2*WIDTH-1:WIDTH];
            bus.LO_out = bus.WriteinRF_HI_LO_data[WIDTH-1:0];
        end
    end

    assign bus.timer_int = timer_int;

endmodule

// File: doc/reg_file_hilo_cp0.md
# reg_file_hilo_cp0

Architectural state store at the end of the writeback path: accepts the register write address/data and HI/LO write produced by the writeback stage and holds the 32 GPRs, the HI/LO pair and a 32-entry CP0 bank, including the free-running Count/Compare timer. Provides two combinational read ports with same-cycle write-through to the decode stage, plus HI/LO and the timer interrupt to execute and exception logic.

## Interface
- WIDTH, 32, data width of GPR/CP0/HI/LO halves
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-high
- RegWriteW  in  1  register write strobe from writeback
- WritetoRFaddr  in  7  unified write address (see Operation)
- WritetoRFdata  in  WIDTH  write data
- HI_LO_writeenable  in  1  HI/LO write strobe
- WriteinRF_HI_LO_data  in  64  {HI, LO} write data
- ReadAddr1, ReadAddr2  in  7 each  unified read addresses
- ReadData1, ReadData2  out  WIDTH each  read data, combinational
- HI_out, LO_out  out  WIDTH each  current HI/LO, combinational with write-through
- timer_int  out  1  registered Count==Compare interrupt

## Operation
- Unified address map: 7'h00–7'h1F = GPR[addr[4:0]]; 7'h40–7'h5F = CP0[addr[4:0]]; all other addresses: writes discarded, reads return 0.
- GPR[0] hardwired 0: writes ignored, reads 0 (also under write-through).
- Write: on rising clk with RegWriteW=1, target register <= WritetoRFdata.
- HI/LO: on rising clk with HI_LO_writeenable=1, HI <= data[63:32], LO <= data[31:0]. Independent of RegWriteW; both may occur in one cycle.
- Read ports: ReadDataN = stored value, except when RegWriteW=1 and ReadAddrN==WritetoRFaddr and address is writable (not GPR0, not unmapped): ReadDataN = WritetoRFdata. Same write-through for HI_out/LO_out when HI_LO_writeenable=1.
- CP0 Count (7'h49): internal phase bit toggles every cycle; Count increments by 1 (mod 2^32, wraps FFFFFFFF->0) on cycles where phase=1.
- Software write to Count wins over increment that cycle; phase bit unaffected.
- CP0 Compare (7'h4B): write clears timer_int in the same edge.
- timer_int set at the edge after Count==Compare holds (Count value as stored, before that edge's increment) and Compare was not written that cycle; stays set until Compare written or reset.
- Other CP0 entries are plain storage.

## Timing
- Reset (async, immediate): all GPR, CP0 (incl. Count, Compare), HI, LO = 0; phase = 0; timer_int = 0. Combinational outputs therefore read 0 during reset (write-through suppressed while rst=1).
- Write latency: stored on the edge; visible to readers same cycle via write-through, from storage the next cycle.
- Count: after reset release, first increment at 2nd rising edge; Count = floor(edges/2).
- Since Count==Compare==0 at reset, timer_int sets at the first edge after reset release unless Compare written that cycle.
- rst asserted mid-cycle with a pending write: write lost, state returns to 0.

## Test plan
- Reset, then write GPR5=0xDEADBEEF; same cycle ReadAddr1=5 -> ReadData1=0xDEADBEEF (write-through); next cycle from storage, same value.
- Write GPR0=0x12345678 with ReadAddr2=0 -> ReadData2=0 same and next cycle; write to 7'h20 then read 7'h20 -> 0.
- HI_LO_writeenable with {0x1,0x2} and RegWriteW GPR3=0x7 same cycle -> HI_out=1, LO_out=2 immediately; GPR3=7 next cycle.
- Free-run 10 edges after reset -> Count=5; write Count=0xFFFFFFFF on a phase=0 cycle, 2 edges later -> 0x00000000.
- Write Compare=4 right after reset -> timer_int clears/stays 0, sets on the edge after Count reaches 4 (9th edge after release); write Compare=100 -> timer_int=0 next edge.
- Assert rst mid-operation with GPR7 written and Count=3 -> all reads 0, timer_int=0 immediately.
